// File: rtl/fft_frame_ctrl.sv
// ============================================================================
// Module   : fft_frame_ctrl
// Purpose  : Frame sequencer in front of a variable-size SDF FFT (4..256
//            points). Latches a per-frame transform size, holds the FFT
//            Stages input stable for the whole frame, admits exactly
//            N = 2^stages samples through a valid/ready handshake, counts
//            N FFT output samples and reports frame completion.
// Ports    : clk, rst (async, active-high)
//            cfg_stages[3:0], start          - frame request (legal 2..8)
//            in_valid, in_re, in_im, in_ready - input sample handshake
//            fft_stages, fft_di_en, fft_di_re, fft_di_im - FFT input side
//            fft_do_en                        - FFT output sample strobe
//            busy, out_cnt[8:0], frame_done, cfg_err, timeout - status
// Options  : FFT_CTRL_TIMEOUT_EN - enables the DRAIN watchdog (DRAIN_MAX
//            idle cycles); when undefined, timeout is tied low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_frame_ctrl #(
   parameter int WIDTH     = 18,
   parameter int DRAIN_MAX = 1023
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       cfg_stages,
   input  logic             start,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_re,
   input  logic [WIDTH-1:0] in_im,
   output logic             in_ready,
   output logic [3:0]       fft_stages,
   output logic             fft_di_en,
   output logic [WIDTH-1:0] fft_di_re,
   output logic [WIDTH-1:0] fft_di_im,
   input  logic             fft_do_en,
   output logic             busy,
   output logic [8:0]       out_cnt,
   output logic             frame_done,
   output logic             cfg_err,
   output logic             timeout
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SETUP = 2'd1;
   localparam logic [1:0] S_LOAD  = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   localparam logic [9:0] C_DRAIN_MAX = 10'(DRAIN_MAX);

   logic [1:0]       state_q, state_d;
   logic             setup_cnt_q, setup_cnt_d;
   logic [8:0]       n_q, n_d;
   logic [8:0]       in_cnt_q, in_cnt_d;
   logic [8:0]       out_cnt_q, out_cnt_d;
   logic             in_ready_q, in_ready_d;
   logic [3:0]       stages_q, stages_d;
   logic             di_en_q, di_en_d;
   logic [WIDTH-1:0] di_re_q, di_re_d;
   logic [WIDTH-1:0] di_im_q, di_im_d;
   logic             frame_done_q, frame_done_d;
   logic             cfg_err_q, cfg_err_d;

   logic w_cfg_ok;
   logic w_accept;
   logic w_count_out;

`ifdef FFT_CTRL_TIMEOUT_EN
   logic [9:0] wd_q, wd_d;
   logic       timeout_q, timeout_d;
`endif

   assign w_cfg_ok = (cfg_stages >= 4'd2) && (cfg_stages <= 4'd8);
   // in_ready_q is only ever set in LOAD, so accepts cannot occur elsewhere.
   assign w_accept = in_valid && in_ready_q;
   // Output samples count in LOAD too: a short frame's FFT latency can
   // overlap its own load phase. Saturates at N.
   assign w_count_out = fft_do_en && ((state_q == S_LOAD) || (state_q == S_DRAIN))
                        && (out_cnt_q != n_q);

   always_comb begin
      state_d      = state_q;
      setup_cnt_d  = setup_cnt_q;
      n_d          = n_q;
      in_cnt_d     = in_cnt_q;
      out_cnt_d    = out_cnt_q;
      in_ready_d   = in_ready_q;
      stages_d     = stages_q;
      di_en_d      = 1'b0;
      di_re_d      = di_re_q;
      di_im_d      = di_im_q;
      frame_done_d = 1'b0;
      cfg_err_d    = 1'b0;
`ifdef FFT_CTRL_TIMEOUT_EN
      wd_d         = wd_q;
      timeout_d    = 1'b0;
`endif

      if (w_accept) begin
         di_en_d  = 1'b1;
         di_re_d  = in_re;
         di_im_d  = in_im;
         in_cnt_d = in_cnt_q + 9'd1;
      end

      if (w_count_out) begin
         out_cnt_d = out_cnt_q + 9'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (w_cfg_ok) begin
                  stages_d    = cfg_stages;
                  n_d         = 9'd1 << cfg_stages;
                  in_cnt_d    = 9'd0;
                  out_cnt_d   = 9'd0;
                  setup_cnt_d = 1'b0;
                  state_d     = S_SETUP;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end

         // Two settle cycles for the FFT's registered size decode.
         S_SETUP: begin
            if (setup_cnt_q) begin
               state_d    = S_LOAD;
               in_ready_d = 1'b1;
            end else begin
               setup_cnt_d = 1'b1;
            end
         end

         S_LOAD: begin
            if (w_accept && (in_cnt_q == (n_q - 9'd1))) begin
               state_d    = S_DRAIN;
               in_ready_d = 1'b0;
`ifdef FFT_CTRL_TIMEOUT_EN
               wd_d       = 10'd0;
`endif
            end
         end

         S_DRAIN: begin
            // Also covers the case where all outputs arrived during LOAD.
            if (out_cnt_d == n_q) begin
               frame_done_d = 1'b1;
               state_d      = S_IDLE;
            end
`ifdef FFT_CTRL_TIMEOUT_EN
            else if (wd_q == C_DRAIN_MAX) begin
               timeout_d = 1'b1;
               state_d   = S_IDLE;
            end else if (fft_do_en) begin
               wd_d = 10'd0;
            end else begin
               wd_d = wd_q + 10'd1;
            end
`endif
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         setup_cnt_q  <= 1'b0;
         n_q          <= 9'd4;
         in_cnt_q     <= 9'd0;
         out_cnt_q    <= 9'd0;
         in_ready_q   <= 1'b0;
         stages_q     <= 4'd2;
         di_en_q      <= 1'b0;
         di_re_q      <= '0;
         di_im_q      <= '0;
         frame_done_q <= 1'b0;
         cfg_err_q    <= 1'b0;
`ifdef FFT_CTRL_TIMEOUT_EN
         wd_q         <= 10'd0;
         timeout_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         setup_cnt_q  <= setup_cnt_d;
         n_q          <= n_d;
         in_cnt_q     <= in_cnt_d;
         out_cnt_q    <= out_cnt_d;
         in_ready_q   <= in_ready_d;
         stages_q     <= stages_d;
         di_en_q      <= di_en_d;
         di_re_q      <= di_re_d;
         di_im_q      <= di_im_d;
         frame_done_q <= frame_done_d;
         cfg_err_q    <= cfg_err_d;
`ifdef FFT_CTRL_TIMEOUT_EN
         wd_q         <= wd_d;
         timeout_q    <= timeout_d;
`endif
      end
   end

   assign in_ready   = in_ready_q;
   assign fft_stages = stages_q;
   assign fft_di_en  = di_en_q;
   assign fft_di_re  = di_re_q;
   assign fft_di_im  = di_im_q;
   assign busy       = (state_q != S_IDLE);
   assign out_cnt    = out_cnt_q;
   assign frame_done = frame_done_q;
   assign cfg_err    = cfg_err_q;

`ifdef FFT_CTRL_TIMEOUT_EN
   assign timeout = timeout_q;
`else
   // Watchdog absent: the limit is intentionally unused in this build.
   logic w_unused_drain_max;
   assign w_unused_drain_max = ^C_DRAIN_MAX;
   assign timeout = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fft_frame_ctrl.sv
`default_nettype none

module tb_fft_frame_ctrl;

   localparam int W = 18;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   cfg_stages;
   logic         start;
   logic         in_valid;
   logic [W-1:0] in_re;
   logic [W-1:0] in_im;
   logic         in_ready;
   logic [3:0]   fft_stages;
   logic         fft_di_en;
   logic [W-1:0] fft_di_re;
   logic [W-1:0] fft_di_im;
   logic         fft_do_en;
   logic         busy;
   logic [8:0]   out_cnt;
   logic         frame_done;
   logic         cfg_err;
   logic         timeout;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fft_frame_ctrl #(.WIDTH(W), .DRAIN_MAX(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_stages (cfg_stages),
      .start      (start),
      .in_valid   (in_valid),
      .in_re      (in_re),
      .in_im      (in_im),
      .in_ready   (in_ready),
      .fft_stages (fft_stages),
      .fft_di_en  (fft_di_en),
      .fft_di_re  (fft_di_re),
      .fft_di_im  (fft_di_im),
      .fft_do_en  (fft_do_en),
      .busy       (busy),
      .out_cnt    (out_cnt),
      .frame_done (frame_done),
      .cfg_err    (cfg_err),
      .timeout    (timeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; sample/drive 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start a frame from IDLE with continuous valid; returns at the first
   // DRAIN cycle (the cycle in which in_ready has just dropped).
   task automatic load_frame(input logic [3:0] s, input int n, input string tag);
      int nacc;
      nacc = 0;
      cfg_stages = s; start = 1'b1; in_valid = 1'b0;
      tick(); start = 1'b0;
      tick(); tick();
      in_valid = 1'b1;
      for (int c = 0; c < n + 4; c++) begin
         if (!in_ready) break;
         in_re = W'(500 + nacc); in_im = W'(600 + nacc);
         nacc++;
         tick();
      end
      in_valid = 1'b0;
      chk({tag, "_accepts"}, nacc, n);
      chk({tag, "_busy_drain"}, busy, 1);
      chk({tag, "_ready_drain"}, in_ready, 0);
   endtask

   // Deliver n back-to-back output strobes and check completion.
   task automatic finish_frame(input int n, input string tag);
      for (int k = 0; k < n; k++) begin
         fft_do_en = 1'b1;
         tick();
      end
      fft_do_en = 1'b0;
      chk({tag, "_done"}, frame_done, 1);
      chk({tag, "_outcnt"}, out_cnt, n);
      chk({tag, "_busy_end"}, busy, 0);
      tick();
      chk({tag, "_done_pulse"}, frame_done, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int acc, den, rdy, nacc, k;
      logic prev, seen_done;

      rst = 1'b1; cfg_stages = 4'd0; start = 1'b0; in_valid = 1'b0;
      in_re = '0; in_im = '0; fft_do_en = 1'b0;
      #12;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_stages", fft_stages, 2);
      chk("rst_di_en", fft_di_en, 0);
      chk("rst_di_re", fft_di_re, 0);
      chk("rst_di_im", fft_di_im, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_cnt", out_cnt, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_timeout", timeout, 0);
      @(negedge clk); rst = 1'b0;
      tick(); tick();

      // ---- Frame 1: 4-point, continuous valid, exact timing ----
      cfg_stages = 4'd2; start = 1'b1; in_valid = 1'b1;
      in_re = W'(100); in_im = W'(200);
      tick();
      chk("f1_busy_t1", busy, 1);
      chk("f1_stages_t1", fft_stages, 2);
      chk("f1_ready_t1", in_ready, 0);
      start = 1'b0;
      fft_do_en = 1'b1;               // lands in SETUP: must be ignored
      tick();
      fft_do_en = 1'b0;
      chk("f1_ready_t2", in_ready, 0);
      tick();
      chk("f1_ready_t3", in_ready, 1);
      chk("f1_setup_do_ignored", out_cnt, 0);
      acc = 0; den = 0; rdy = 0;
      for (int c = 0; c < 8; c++) begin
         in_re = W'(100 + acc); in_im = W'(200 + acc);
         if (fft_di_en) begin
            chk("f1_di_re", fft_di_re, 100 + den);
            chk("f1_di_im", fft_di_im, 200 + den);
            den++;
         end
         if (in_ready) begin
            rdy++;
            acc++;
         end
         tick();
      end
      in_valid = 1'b0;
      chk("f1_ready_cycles", rdy, 4);
      chk("f1_di_en_pulses", den, 4);
      chk("f1_ready_after", in_ready, 0);
      chk("f1_busy_drain", busy, 1);
      for (int j = 0; j < 4; j++) begin
         fft_do_en = 1'b1;
         tick();
         fft_do_en = 1'b0;
         chk("f1_out_cnt", out_cnt, j + 1);
         chk("f1_frame_done", frame_done, (j == 3) ? 1 : 0);
         chk("f1_busy", busy, (j == 3) ? 0 : 1);
         if (j < 3) tick();
      end
      tick();
      chk("f1_done_pulse", frame_done, 0);
      fft_do_en = 1'b1;               // in IDLE: ignored
      tick();
      fft_do_en = 1'b0;
      chk("f1_idle_do_ignored", out_cnt, 4);

      // ---- Illegal configurations ----
      cfg_stages = 4'd9; start = 1'b1;
      tick();
      start = 1'b0;
      chk("ill9_cfg_err", cfg_err, 1);
      chk("ill9_busy", busy, 0);
      chk("ill9_stages", fft_stages, 2);
      tick();
      chk("ill9_err_pulse", cfg_err, 0);
      chk("ill9_busy_after", busy, 0);
      cfg_stages = 4'd1; start = 1'b1;
      tick();
      start = 1'b0;
      chk("ill1_cfg_err", cfg_err, 1);
      chk("ill1_busy", busy, 0);
      tick();

      // ---- Frame 3: 8-point with backpressure, start while busy ----
      cfg_stages = 4'd3; start = 1'b1; in_valid = 1'b0;
      tick(); start = 1'b0;
      tick(); tick();
      chk("f3_ready_load", in_ready, 1);
      chk("f3_stages", fft_stages, 3);
      nacc = 0; prev = 1'b0;
      for (int c = 0; c < 22; c++) begin
         if (prev) nacc++;
         chk("f3_di_en", fft_di_en, prev);
         if (nacc > 0) chk("f3_di_re", fft_di_re, 300 + nacc - 1);
         chk("f3_stages_hold", fft_stages, 3);
         chk("f3_no_cfg_err", cfg_err, 0);
         start      = (c == 2);
         cfg_stages = (c == 2) ? 4'd5 : 4'd3;
         fft_do_en  = (c == 4) || (c == 8);
         in_valid   = (c % 2 == 0);
         in_re = W'(300 + nacc); in_im = W'(400 + nacc);
         prev = in_valid && in_ready;
         tick();
      end
      start = 1'b0; in_valid = 1'b0; fft_do_en = 1'b0;
      chk("f3_accepts", nacc, 8);
      chk("f3_ready_after", in_ready, 0);
      chk("f3_load_do_counted", out_cnt, 2);
      for (int j = 0; j < 6; j++) begin
         fft_do_en = 1'b1;
         tick();
         fft_do_en = 1'b0;
         chk("f3_out_cnt", out_cnt, 3 + j);
         chk("f3_frame_done", frame_done, (j == 5) ? 1 : 0);
      end
      tick();
      chk("f3_idle", busy, 0);
      chk("f3_stages_idle", fft_stages, 3);

      // ---- Reset in the middle of a 16-point load ----
      cfg_stages = 4'd4; start = 1'b1;
      tick(); start = 1'b0;
      tick(); tick();
      in_valid = 1'b1; fft_do_en = 1'b1;
      tick();
      fft_do_en = 1'b0;
      tick(); tick();
      chk("rm_pre_outcnt", out_cnt, 1);
      chk("rm_pre_stages", fft_stages, 4);
      #2 rst = 1'b1;
      #1;
      chk("rm_busy", busy, 0);
      chk("rm_ready", in_ready, 0);
      chk("rm_stages", fft_stages, 2);
      chk("rm_outcnt", out_cnt, 0);
      chk("rm_di_en", fft_di_en, 0);
      chk("rm_done", frame_done, 0);
      chk("rm_timeout", timeout, 0);
      in_valid = 1'b0;
      @(negedge clk); rst = 1'b0;
      tick();
      chk("rm_done_after", frame_done, 0);
      load_frame(4'd2, 4, "rn");
      finish_frame(4, "rn");

      // ---- Drain watchdog ----
      load_frame(4'd2, 4, "wd");
`ifdef FFT_CTRL_TIMEOUT_EN
      k = 0; seen_done = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (timeout) break;
         if (frame_done) seen_done = 1'b1;
         tick();
         k++;
      end
      chk("wd_delay", k, 17);
      chk("wd_timeout", timeout, 1);
      chk("wd_busy", busy, 0);
      chk("wd_no_done", frame_done, 0);
      chk("wd_no_done_seen", seen_done, 0);
      tick();
      chk("wd_pulse", timeout, 0);
`else
      k = 0; seen_done = 1'b0;
      for (int c = 0; c < 30; c++) begin
         if (timeout) k++;
         if (frame_done) seen_done = 1'b1;
         tick();
      end
      chk("nowd_timeout", k, 0);
      chk("nowd_no_done", seen_done, 0);
      chk("nowd_busy", busy, 1);
      finish_frame(4, "nowd");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
